bird_column: RTL and testbench

- Parametrised successor to the fixed 16-light bird column; holds the bird's vertical position in one column of the LED matrix.
- Drives a one-hot light vector for the display path and moves the bird up on push and down on gravity ticks.
- Adds a multi-row jump, a gravity divider, a crash/freeze state and restart; feeds the collision and score logic.

---
 rtl/bird_column.sv | 87 ++++++++
 tb/tb_bird_column.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bird_column.sv
// bird_column: one-hot bird row for one LED column; push jumps up, divided gravity drops, ground hit freezes until restart.
// All outputs registered, 1-cycle latency, no backpressure; optional BIRD_CEILING_CRASH_EN makes a top-saturating push crash.
module bird_column #(
    parameter int HEIGHT    = 16,
    parameter int START_POS = 10,
    parameter int JUMP      = 1,
    parameter int FALL_DIV  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      fall,
    input  logic                      restart,
    output logic [HEIGHT-1:0]         lights,
    output logic [$clog2(HEIGHT)-1:0] pos,
    output logic                      crashed
);
    localparam int POS_W = $clog2(HEIGHT);
    localparam logic [POS_W-1:0]  START_P  = POS_W'(START_POS);
    localparam logic [POS_W-1:0]  JUMP_P   = POS_W'(JUMP);
    localparam logic [POS_W-1:0]  BOTTOM   = POS_W'(HEIGHT - 1);
    localparam logic [3:0]        LAST_CNT = 4'(FALL_DIV - 1);
    localparam logic [HEIGHT-1:0] ONE      = {{(HEIGHT-1){1'b0}}, 1'b1};

    typedef enum logic {PLAY, CRASHED} state_t;

    state_t           state, nxt_state;
    logic [3:0]       div_cnt, nxt_cnt;
    logic [POS_W-1:0] nxt_pos;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = div_cnt;
        nxt_pos   = pos;
        case (state)
            PLAY: begin
                if (push) begin
                    nxt_cnt = '0;
                    if (pos >= JUMP_P) begin
                        nxt_pos = pos - JUMP_P;
                    end else begin
                        nxt_pos = '0;
`ifdef BIRD_CEILING_CRASH_EN
                        nxt_state = CRASHED;
`endif
                    end
                end else if (fall) begin
                    if (div_cnt == LAST_CNT) begin
                        nxt_cnt = '0;
                        // A drop from the ground row is the crash; the bird stays visible there.
                        if (pos == BOTTOM) begin
                            nxt_state = CRASHED;
                        end else begin
                            nxt_pos = pos + POS_W'(1);
                        end
                    end else begin
                        nxt_cnt = div_cnt + 4'd1;
                    end
                end
            end
            CRASHED: begin
                if (restart) begin
                    nxt_state = PLAY;
                    nxt_pos   = START_P;
                    nxt_cnt   = '0;
                end
            end
            default: nxt_state = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= PLAY;
            pos     <= START_P;
            lights  <= ONE << START_P;
            crashed <= 1'b0;
            div_cnt <= '0;
        end else begin
            state   <= nxt_state;
            pos     <= nxt_pos;
            lights  <= ONE << nxt_pos;
            crashed <= (nxt_state == CRASHED);
            div_cnt <= nxt_cnt;
        end
    end
endmodule

// File: tb/tb_bird_column.sv
// Bench for bird_column: table of vectors on a 16-row column plus hand sequences for ceiling and an 8-row column.
module tb_bird_column;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, push, fall, restart;
    logic [15:0] lights;
    logic [3:0]  pos;
    logic        crashed;

    logic        reset_b, push_b, fall_b, restart_b;
    logic [7:0]  lights_b;
    logic [2:0]  pos_b;
    logic        crashed_b;

    bird_column #(.HEIGHT(16), .START_POS(10), .JUMP(2), .FALL_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .push(push), .fall(fall), .restart(restart),
        .lights(lights), .pos(pos), .crashed(crashed)
    );

    bird_column #(.HEIGHT(8), .START_POS(3), .JUMP(3), .FALL_DIV(1)) dut_b (
        .clk(clk), .reset(reset_b), .push(push_b), .fall(fall_b), .restart(restart_b),
        .lights(lights_b), .pos(pos_b), .crashed(crashed_b)
    );

    typedef struct {
        logic rst_n;
        logic push;
        logic fall;
        logic restart;
        int   exp_pos;
        logic exp_crashed;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef BIRD_CEILING_CRASH_EN
    localparam logic CEIL_CRASH = 1'b1;
`else
    localparam logic CEIL_CRASH = 1'b0;
`endif

    task automatic add(input logic r, input logic p, input logic f, input logic rs,
                       input int ep, input logic ec);
        vec_t v;
        v.rst_n = r; v.push = p; v.fall = f; v.restart = rs;
        v.exp_pos = ep; v.exp_crashed = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step_a(input logic r, input logic p, input logic f, input logic rs);
        @(negedge clk);
        reset = r; push = p; fall = f; restart = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic r, input logic p, input logic f, input logic rs);
        @(negedge clk);
        reset_b = r; push_b = p; fall_b = f; restart_b = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] one16;
        int          ep;
        one16 = 16'h0001;
        reset = 1'b0; push = 1'b0; fall = 1'b0; restart = 1'b0;
        reset_b = 1'b0; push_b = 1'b0; fall_b = 1'b0; restart_b = 1'b0;

        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 10, 0);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 10, 0);
        add(1, 0, 1, 0, 10, 0);
        add(1, 0, 1, 0, 11, 0);
        add(1, 0, 1, 0, 11, 0);
        add(1, 0, 1, 0, 12, 0);
        add(1, 1, 0, 0, 10, 0);
        add(1, 0, 1, 0, 10, 0);
        add(1, 1, 1, 0, 8, 0);
        add(1, 0, 0, 1, 8, 0);
        for (int k = 1; k <= 16; k++) begin
            ep = 8 + k / 2;
            add(1, 0, 1, 0, (ep > 15) ? 15 : ep, (k == 16));
        end
        add(1, 1, 0, 0, 15, 1);
        add(1, 0, 1, 0, 15, 1);
        add(1, 1, 1, 0, 15, 1);
        add(1, 0, 0, 1, 10, 0);
        add(1, 1, 0, 0, 8, 0);
        for (int k = 1; k <= 16; k++) begin
            ep = 8 + k / 2;
            add(1, 0, 1, 0, (ep > 15) ? 15 : ep, (k == 16));
        end
        add(0, 0, 0, 1, 10, 0);
        add(1, 0, 1, 0, 10, 0);
        add(0, 1, 0, 0, 10, 0);

        foreach (vecs[i]) begin
            step_a(vecs[i].rst_n, vecs[i].push, vecs[i].fall, vecs[i].restart);
            check("pos", i, 64'(pos), 64'(vecs[i].exp_pos));
            check("crashed", i, 64'(crashed), 64'(vecs[i].exp_crashed));
            check("lights", i, 64'(lights), 64'(one16 << vecs[i].exp_pos));
        end

        // Climb to row 1, then push into the ceiling twice.
        step_a(1, 0, 1, 0);
        step_a(1, 0, 1, 0);
        check("ceil_pre_pos", 0, 64'(pos), 64'd11);
        for (int i = 0; i < 5; i++) step_a(1, 1, 0, 0);
        check("ceil_row1_pos", 0, 64'(pos), 64'd1);
        step_a(1, 1, 0, 0);
        check("ceil_pos", 1, 64'(pos), 64'd0);
        check("ceil_lights", 1, 64'(lights), 64'h0001);
        check("ceil_crashed", 1, 64'(crashed), 64'(CEIL_CRASH));
        step_a(1, 1, 0, 0);
        check("ceil_pos", 2, 64'(pos), 64'd0);
        check("ceil_crashed", 2, 64'(crashed), 64'(CEIL_CRASH));
        step_a(0, 0, 0, 0);
        check("ceil_reset_pos", 0, 64'(pos), 64'd10);

        step_a(1, 0, 0, 0);
        step_b(1, 0, 0, 0);
        check("b_idle_pos", 0, 64'(pos_b), 64'd3);
        check("b_idle_lights", 0, 64'(lights_b), 64'h08);
        for (int k = 1; k <= 5; k++) begin
            step_b(1, 0, 1, 0);
            check("b_fall_pos", k, 64'(pos_b), 64'((k >= 4) ? 7 : 3 + k));
            check("b_fall_crashed", k, 64'(crashed_b), 64'(k == 5));
        end
        check("b_crash_lights", 0, 64'(lights_b), 64'h80);
        step_b(1, 1, 0, 0);
        check("b_frozen_pos", 0, 64'(pos_b), 64'd7);
        check("b_frozen_crashed", 0, 64'(crashed_b), 64'd1);
        step_b(1, 0, 0, 1);
        check("b_restart_pos", 0, 64'(pos_b), 64'd3);
        check("b_restart_crashed", 0, 64'(crashed_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
